// File: rtl/lock_ctrl.sv
// Keypad lock controller: opens on a correct entry, and locks out with an alarm after too many wrong entries.
// Latency: unlocked/alarm/fail_cnt change on the clock edge after the press-edge cycle.
// Backpressure: none; every press edge is acted on or ignored in the cycle it occurs.
//
// Ports:
//   clk       system clock; all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   keypress  keypad key level; a press is its 0->1 transition
//   res       password-match result, sampled only in the press-edge cycle
//   unlocked  high while the lock is open
//   alarm     high during lockout
//   fail_cnt  number of consecutive wrong entries (saturates at MAX_FAIL)
module lock_ctrl #(
    parameter int UNLOCK_CYCLES  = 16,  // 1..255
    parameter int LOCKOUT_CYCLES = 32,  // 1..255
    parameter int MAX_FAIL       = 3    // 1..3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       keypress,
    input  logic       res,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] fail_cnt
);

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam logic [7:0] UNLOCK_LOAD  = 8'(UNLOCK_CYCLES - 1);
    localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] MAX_FAIL_W   = 3'(MAX_FAIL);
    localparam logic [1:0] MAX_FAIL_SAT = 2'(MAX_FAIL);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic [7:0] timer_nxt;
    logic [1:0] fail_cnt_nxt;
    logic       keypress_d;
    logic       press_edge;
    logic [2:0] fail_inc;

    assign press_edge = keypress & ~keypress_d;
    // One bit wider than fail_cnt so the compare against MAX_FAIL cannot wrap.
    assign fail_inc   = {1'b0, fail_cnt} + 3'd1;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        fail_cnt_nxt = fail_cnt;
        case (state)
            LOCKED: begin
                if (press_edge) begin
                    if (res) begin
                        state_nxt    = OPEN;
                        fail_cnt_nxt = 2'd0;
                        timer_nxt    = UNLOCK_LOAD;
                    end else if (fail_inc < MAX_FAIL_W) begin
                        fail_cnt_nxt = fail_inc[1:0];
                    end else begin
                        state_nxt    = LOCKOUT;
                        fail_cnt_nxt = MAX_FAIL_SAT;
                        timer_nxt    = LOCKOUT_LOAD;
                    end
                end
            end
            OPEN: begin
                // Any press while open relocks at once, whatever the match result.
                if (press_edge || timer == 8'd0) begin
                    state_nxt = LOCKED;
                    timer_nxt = 8'd0;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            LOCKOUT: begin
                // Presses are deliberately ignored; only the timer ends lockout.
                if (timer == 8'd0) begin
                    state_nxt    = LOCKED;
                    fail_cnt_nxt = 2'd0;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            default: begin
                state_nxt    = LOCKED;
                timer_nxt    = 8'd0;
                fail_cnt_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOCKED;
            timer      <= 8'd0;
            fail_cnt   <= 2'd0;
            // Reset to 1 so a key held through reset release is not seen as a press.
            keypress_d <= 1'b1;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            fail_cnt   <= fail_cnt_nxt;
            keypress_d <= keypress;
            // Flopped copies of the state decode, so they always track the state register.
            unlocked   <= (state_nxt == OPEN);
            alarm      <= (state_nxt == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_lock_ctrl.sv
module tb_lock_ctrl;

    logic       clk;
    logic       rst_n;
    logic       keypress;
    logic       res;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fail_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected output change: the cycle it is seen in and {unlocked, alarm, fail_cnt}.
    typedef struct {
        int         c;
        logic [3:0] val;
    } ev_t;
    ev_t        q[$];
    logic [3:0] prev = 4'b0000;

    lock_ctrl #(
        .UNLOCK_CYCLES (16),
        .LOCKOUT_CYCLES(32),
        .MAX_FAIL      (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .keypress(keypress),
        .res     (res),
        .unlocked(unlocked),
        .alarm   (alarm),
        .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_ev(input int c, input logic u, input logic a, input logic [1:0] f);
        ev_t e;
        e.c   = c;
        e.val = {u, a, f};
        q.push_back(e);
    endfunction

    // Monitor: every change of the outputs must match the next queued expectation.
    always @(negedge clk) begin
        logic [3:0] obs;
        ev_t        e;
        obs = {unlocked, alarm, fail_cnt};
        n_chk++;
        if (unlocked === 1'b1 && alarm === 1'b1) begin
            n_fail++;
            $display("FAIL exclusive: unlocked and alarm both high at cycle %0d", cyc);
        end
        if (obs !== prev) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_change: got %b at cycle %0d, none expected", obs, cyc);
            end else begin
                e = q.pop_front();
                n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL event_value: got %b, expected %b (cycle %0d)", obs, e.val, cyc);
                end
                n_chk++;
                if (cyc != e.c) begin
                    n_fail++;
                    $display("FAIL event_cycle: value %b seen at cycle %0d, expected cycle %0d", obs, cyc, e.c);
                end
            end
            prev = obs;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle press: the edge is taken on the next clock edge.
    task automatic press(input logic r);
        keypress = 1'b1;
        res      = r;
        tick(1);
        keypress = 1'b0;
        res      = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        keypress = 1'b0;
        res      = 1'b0;
        #2;
        check_now("reset_state", {unlocked, alarm, fail_cnt}, 4'b0000);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Correct entry: open for exactly 16 cycles.
        n = cyc;
        expect_ev(n + 1, 1'b1, 1'b0, 2'd0);
        expect_ev(n + 17, 1'b0, 1'b0, 2'd0);
        press(1'b1);
        tick(20);

        // Three wrong entries -> lockout of 32 cycles; a correct press inside it is ignored.
        n = cyc; expect_ev(n + 1, 1'b0, 1'b0, 2'd1); press(1'b0); tick(2);
        n = cyc; expect_ev(n + 1, 1'b0, 1'b0, 2'd2); press(1'b0); tick(2);
        n = cyc;
        expect_ev(n + 1, 1'b0, 1'b1, 2'd3);
        expect_ev(n + 33, 1'b0, 1'b0, 2'd0);
        press(1'b0);
        tick(9);
        press(1'b1);
        tick(28);

        // Early relock: a second press five cycles into OPEN.
        n = cyc;
        expect_ev(n + 1, 1'b1, 1'b0, 2'd0);
        press(1'b1);
        tick(4);
        n = cyc;
        expect_ev(n + 1, 1'b0, 1'b0, 2'd0);
        press(1'b0);
        tick(4);

        // Held key: one OPEN period only.
        n = cyc;
        expect_ev(n + 1, 1'b1, 1'b0, 2'd0);
        expect_ev(n + 17, 1'b0, 1'b0, 2'd0);
        keypress = 1'b1;
        res      = 1'b1;
        tick(10);
        keypress = 1'b0;
        res      = 1'b0;
        tick(12);

        // Two wrong then one correct entry clears fail_cnt.
        n = cyc; expect_ev(n + 1, 1'b0, 1'b0, 2'd1); press(1'b0); tick(2);
        n = cyc; expect_ev(n + 1, 1'b0, 1'b0, 2'd2); press(1'b0); tick(2);
        n = cyc;
        expect_ev(n + 1, 1'b1, 1'b0, 2'd0);
        expect_ev(n + 17, 1'b0, 1'b0, 2'd0);
        press(1'b1);
        tick(20);

        // Async reset mid-lockout with the key held high.
        n = cyc; expect_ev(n + 1, 1'b0, 1'b0, 2'd1); press(1'b0); tick(2);
        n = cyc; expect_ev(n + 1, 1'b0, 1'b0, 2'd2); press(1'b0); tick(2);
        n = cyc; expect_ev(n + 1, 1'b0, 1'b1, 2'd3); press(1'b0); tick(5);
        keypress = 1'b1;
        res      = 1'b1;
        tick(2);
        n = cyc;
        expect_ev(n, 1'b0, 1'b0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_clear", {unlocked, alarm, fail_cnt}, 4'b0000);
        rst_n = 1'b1;
        tick(6);
        keypress = 1'b0;
        res      = 1'b0;
        tick(2);
        n = cyc;
        expect_ev(n + 1, 1'b1, 1'b0, 2'd0);
        expect_ev(n + 17, 1'b0, 1'b0, 2'd0);
        press(1'b1);
        tick(20);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d expected output changes never seen, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Parameters
REQ-001 UNLOCK_CYCLES, 16, number of cycles the lock stays open after a correct entry; legal range 1..255.
REQ-002 LOCKOUT_CYCLES, 32, number of cycles of alarm/lockout after too many failures; legal range 1..255.
REQ-003 MAX_FAIL, 3, number of consecutive wrong entries that triggers lockout; legal range 1..3.

Interface
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 keypress  input  1  key-press level from the keypad, synchronous to clk; a press is its 0->1 transition.
REQ-007 res  input  1  password-match result from the upstream comparator (match AND keypress); valid in the press-edge cycle.
REQ-008 unlocked  output  1  registered; high while the lock is open.
REQ-009 alarm  output  1  registered; high during lockout.
REQ-010 fail_cnt  output  2  registered; count of consecutive wrong entries.

Function
REQ-011 The block SHALL register keypress into keypress_d and define press_edge = keypress AND NOT keypress_d.
REQ-012 The state machine SHALL have exactly three states: LOCKED, OPEN and LOCKOUT.
REQ-013 An 8-bit down-counter timer SHALL time both OPEN and LOCKOUT.
REQ-014 LOCKED, press_edge with res=1: the next state SHALL be OPEN, with fail_cnt cleared to 0 and timer loaded with UNLOCK_CYCLES-1.
REQ-015 LOCKED, press_edge with res=0, fail_cnt+1 < MAX_FAIL: the state SHALL stay LOCKED and fail_cnt SHALL increment.
REQ-016 LOCKED, press_edge with res=0, fail_cnt+1 = MAX_FAIL: the next state SHALL be LOCKOUT, with fail_cnt set to MAX_FAIL and timer loaded with LOCKOUT_CYCLES-1.
REQ-017 In LOCKED without press_edge, the state and fail_cnt SHALL hold.
REQ-018 OPEN: unlocked=1; the timer SHALL decrement each cycle; at timer=0 the next state SHALL be LOCKED.
REQ-019 OPEN: a press_edge SHALL force the next state to LOCKED immediately, regardless of res and of the timer value; fail_cnt SHALL be unchanged.
REQ-020 OPEN: unlocked SHALL be high for exactly UNLOCK_CYCLES cycles when no press occurs.
REQ-021 LOCKOUT: alarm=1; every press_edge SHALL be ignored; the timer SHALL decrement each cycle.
REQ-022 LOCKOUT: at timer=0 the next state SHALL be LOCKED with fail_cnt cleared to 0.
REQ-023 LOCKOUT: alarm SHALL be high for exactly LOCKOUT_CYCLES cycles.
REQ-024 unlocked and alarm SHALL be decoded from the registered state, giving 1-cycle latency from the press_edge cycle; they SHALL never be high simultaneously.
REQ-025 A key held high SHALL produce only one press_edge; res SHALL be ignored outside press_edge cycles.
REQ-026 fail_cnt SHALL saturate: it SHALL never exceed MAX_FAIL and SHALL never wrap.
REQ-027 The timer SHALL never underflow, because a state exit occurs at timer=0.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state=LOCKED, unlocked=0, alarm=0, fail_cnt=0, timer=0, keypress_d=1.
REQ-029 The keypress_d reset value of 1 SHALL ensure that a key held high across reset release produces no press_edge until it is released and pressed again.
REQ-030 Reset asserted mid-OPEN or mid-LOCKOUT SHALL clear the outputs asynchronously, without waiting for a clock edge.

Verification
REQ-031 Correct entry: after reset, keypress 0->1 with res=1 -> unlocked=1 from the next cycle for exactly 16 cycles; alarm=0; fail_cnt=0.
REQ-032 Lockout: three separate presses with res=0 -> fail_cnt goes 1, 2, 3; after the 3rd, alarm=1 for exactly 32 cycles; then fail_cnt=0 and the state is LOCKED.
REQ-033 Lockout ignores presses: a press with res=1 during alarm -> no unlock and no timer change; alarm still drops on the original schedule.
REQ-034 Early relock: press res=1, then a second press 5 cycles into OPEN -> unlocked drops the cycle after the second edge.
REQ-035 Held key: keypress held high for 10 cycles with res=1 -> exactly one OPEN period; two wrong presses followed by one correct press -> fail_cnt returns to 0.
REQ-036 Async reset: rst_n pulsed low mid-LOCKOUT with keypress held high -> alarm=0 immediately; no press_edge after release until keypress goes low then high.
